// File: rtl/fp_pkg.sv
// Shared FP constants and types.
// Class tags and field bounds for IEEE-754 single precision.
package fp_pkg;

  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int MAN_MSB = 22;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_DENORM = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fpCls_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACK    = 2'd1,
    WAITLO = 2'd2
  } inState_e;

endpackage

// File: rtl/fp_classify.sv
// IEEE-754 single-precision class tag.
// Purely combinational; the sign bit does not affect the class.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] value,
  output fpCls_e      cls
);

  logic [7:0] expo;
  logic [MAN_MSB:0] man;
  logic unusedSign;

  assign expo = value[EXP_MSB:EXP_LSB];
  assign man = value[MAN_MSB:0];
  assign unusedSign = value[31];

  // Decode exponent/mantissa into a class tag
  always_comb begin
    cls = CLS_NORMAL;
    if (expo == 8'h00) begin
      cls = (man == '0) ? CLS_ZERO : CLS_DENORM;
    end else if (expo == EXP_ALL1) begin
      cls = (man == '0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp_result_queue.sv
// Result FIFO behind the multiplier handshake.
// Captures once per resultready assertion; head is class-tagged.
module fp_result_queue
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          resultready,
  input  logic [31:0]   ResultBus,
  output logic          resultaccept,
  input  logic          rdReq,
  output logic [31:0]   dataOut,
  output logic [2:0]    cls,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count
);

  localparam int PW = CW - 1;

  logic [31:0] mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] cnt;
  inState_e state;
  inState_e stateNxt;
  logic push;
  logic pop;
  logic [31:0] head;
  fpCls_e headCls;

  assign full = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign pop = rdReq && !empty;
  assign head = mem[rdPtr];

  // Input handshake next-state; push only from IDLE with space
  always_comb begin
    stateNxt = state;
    push = 1'b0;
    unique case (state)
      IDLE: begin
        if (resultready && !full) begin
          push = 1'b1;
          stateNxt = ACK;
        end
      end
      ACK: stateNxt = WAITLO;
      WAITLO: begin
        if (!resultready) stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  // FSM state and registered acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      resultaccept <= 1'b0;
    end else begin
      state <= stateNxt;
      resultaccept <= push;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      if (push && !pop) cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // Storage write; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= ResultBus;
  end

  fp_classify uClassify (
    .value(head),
    .cls  (headCls)
  );

  assign dataOut = empty ? 32'h0 : head;
  assign cls = empty ? CLS_ZERO : headCls;

endmodule

// File: tb/tb_fp_result_queue.sv
// Bench for fp_result_queue.
// Queue reference model plus directed and random traffic.
module tb_fp_result_queue;

  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resultready = 1'b0;
  logic [31:0] ResultBus = 32'h0;
  logic rdReq = 1'b0;
  logic resultaccept;
  logic [31:0] dataOut;
  logic [2:0] cls;
  logic empty;
  logic full;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  fp_result_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .resultready (resultready),
    .ResultBus   (ResultBus),
    .resultaccept(resultaccept),
    .rdReq       (rdReq),
    .dataOut     (dataOut),
    .cls         (cls),
    .empty       (empty),
    .full        (full),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] refCls(input logic [31:0] v);
    logic [7:0] e;
    logic [22:0] m;
    e = v[30:23];
    m = v[22:0];
    if (e == 8'd0) return (m == 0) ? 3'd0 : 3'd1;
    if (e == 8'd255) return (m == 0) ? 3'd3 : 3'd4;
    return 3'd2;
  endfunction

  function automatic logic [31:0] rndVal();
    logic s;
    logic [22:0] m;
    logic [7:0] e;
    s = 1'($urandom);
    m = 23'($urandom);
    e = 8'($urandom_range(1, 254));
    case ($urandom_range(0, 4))
      0: return {s, 8'h00, 23'h0};
      1: return {s, 8'h00, m | 23'h1};
      2: return {s, 8'hFF, 23'h0};
      3: return {s, 8'hFF, m | 23'h1};
      default: return {s, e, m};
    endcase
  endfunction

  // Reference model: inputs seen at each edge, checked mid-cycle
  logic sRst = 1'b1;
  logic sRd = 1'b0;
  logic sRr = 1'b0;
  logic [31:0] sBus = 32'h0;
  logic prevAcc = 1'b0;
  logic [31:0] q[$];

  always @(posedge clk) begin
    sRst <= rst;
    sRd <= rdReq;
    sRr <= resultready;
    sBus <= ResultBus;
  end

  always @(negedge clk) begin
    int pre;
    if (sRst) begin
      q.delete();
      chk("accRst", 32'(resultaccept), 0);
    end else begin
      pre = q.size();
      if (sRd && pre > 0) void'(q.pop_front());
      if (resultaccept) begin
        chk("accWhileFull", 32'(pre < DEPTH), 1);
        chk("accNoReq", 32'(sRr), 1);
        chk("accTwice", 32'(prevAcc), 0);
        q.push_back(sBus);
      end
    end
    prevAcc = resultaccept;
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("dataOut", dataOut, (q.size() > 0) ? q[0] : 32'h0);
    chk("cls", 32'(cls), (q.size() > 0) ? 32'(refCls(q[0])) : 0);
  end

  task automatic pushVal(input logic [31:0] v);
    int n;
    @(negedge clk);
    resultready = 1'b1;
    ResultBus = v;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resultaccept && n < 20);
    chk("ackSeen", 32'(resultaccept), 1);
    resultready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic popOne();
    @(negedge clk);
    rdReq = 1'b1;
    @(negedge clk);
    rdReq = 1'b0;
  endtask

  typedef struct {
    logic [31:0] v;
    logic [2:0] c;
  } clsVec_t;

  clsVec_t clsTab[5];
  logic [31:0] seq[10];

  initial begin
    int n;
    int pulses;
    int gap;
    int waitCnt;

    clsTab[0] = '{32'h00000000, 3'd0};
    clsTab[1] = '{32'h00000001, 3'd1};
    clsTab[2] = '{32'h7F800000, 3'd3};
    clsTab[3] = '{32'h7FC00000, 3'd4};
    clsTab[4] = '{32'h3F800000, 3'd2};

    // Reset values
    repeat (3) @(negedge clk);
    chk("rstEmpty", 32'(empty), 1);
    chk("rstCount", 32'(count), 0);
    chk("rstAcc", 32'(resultaccept), 0);
    chk("rstData", dataOut, 0);
    chk("rstCls", 32'(cls), 0);
    chk("rstFull", 32'(full), 0);
    rst = 1'b0;

    // Single result with pulse count
    @(negedge clk);
    resultready = 1'b1;
    ResultBus = 32'h40490FDB;
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (resultaccept) begin
        pulses++;
        resultready = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    chk("singlePulses", pulses, 1);
    chk("singleCount", 32'(count), 1);
    chk("singleData", dataOut, 32'h40490FDB);
    chk("singleCls", 32'(cls), 2);
    popOne();

    // Class sweep
    for (int i = 0; i < 5; i++) begin
      pushVal(clsTab[i].v);
      chk("sweepData", dataOut, clsTab[i].v);
      chk("sweepCls", 32'(cls), 32'(clsTab[i].c));
      popOne();
    end

    // Fill, then hold a fifth while full
    for (int i = 0; i < DEPTH; i++) pushVal(32'h3F000000 + i);
    @(negedge clk);
    resultready = 1'b1;
    ResultBus = 32'hC0A00000;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (resultaccept) pulses++;
    end
    chk("noAckFull", pulses, 0);
    chk("fullHeld", 32'(full), 1);
    rdReq = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdReq = 1'b0;
      n++;
    end while (!resultaccept && n < 4);
    chk("ackAfterPop", 32'(resultaccept && n <= 2), 1);
    chk("countRefill", 32'(count), 4);
    resultready = 1'b0;
    repeat (2) @(negedge clk);
    repeat (DEPTH) popOne();

    // Held request gives one capture
    @(negedge clk);
    resultready = 1'b1;
    ResultBus = 32'h12345678;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (resultaccept) pulses++;
    end
    resultready = 1'b0;
    repeat (2) @(negedge clk);
    chk("heldPulses", pulses, 1);
    chk("heldCount", 32'(count), 1);
    popOne();

    // Simultaneous push/pop across wrap
    for (int i = 0; i < 10; i++) seq[i] = 32'h40000000 + 32'(i * 17);
    pushVal(seq[0]);
    pushVal(seq[1]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      resultready = 1'b1;
      ResultBus = seq[i + 2];
      rdReq = 1'b1;
      @(negedge clk);
      rdReq = 1'b0;
      chk("pairAck", 32'(resultaccept), 1);
      resultready = 1'b0;
      chk("pairCount", 32'(count), 2);
      chk("pairHead", dataOut, seq[i + 1]);
      repeat (2) @(negedge clk);
    end
    popOne();
    chk("pairTail", dataOut, seq[9]);
    popOne();

    // Reset while in ACK
    @(negedge clk);
    resultready = 1'b1;
    ResultBus = 32'h41200000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resultaccept && n < 20);
    chk("ackBeforeRst", 32'(resultaccept), 1);
    rst = 1'b1;
    resultready = 1'b0;
    @(negedge clk);
    chk("ackRstAcc", 32'(resultaccept), 0);
    chk("ackRstCount", 32'(count), 0);
    rst = 1'b0;
    pushVal(32'h42C80000);
    chk("postRstCount", 32'(count), 1);
    chk("postRstData", dataOut, 32'h42C80000);
    popOne();

    // Random traffic against the model
    gap = 0;
    waitCnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rdReq = ($urandom_range(0, 2) == 0);
      if (resultready && resultaccept) begin
        resultready = 1'b0;
        gap = 2 + $urandom_range(0, 2);
        waitCnt = 0;
      end else if (resultready) begin
        waitCnt++;
        if (waitCnt > 200) begin
          chk("randAckTimeout", 32'(resultaccept), 1);
          resultready = 1'b0;
          gap = 2;
          waitCnt = 0;
        end
      end else if (gap > 0) begin
        gap--;
      end else if ($urandom_range(0, 1) == 1) begin
        resultready = 1'b1;
        ResultBus = rndVal();
      end
    end
    @(negedge clk);
    resultready = 1'b0;
    rdReq = 1'b1;
    repeat (10) @(negedge clk);
    rdReq = 1'b0;
    @(negedge clk);
    chk("drainEmpty", 32'(empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
